fill_arbiter: RTL and testbench

- Arbitrates the single SDRAM controller port between the program cache line-fill requester and the data cache line-fill/write-back requester of the RIPTIDE_II core.
- Sequences each granted transaction as a fixed-length burst by counting beats.
- Routes read beats only to the granted side and write-data advance strobes only to the data side.
- Signals transaction completion so each cache can release its p_cache_miss/d_cache_miss stall.

---
 rtl/fill_arbiter_if.sv | 39 +++
 rtl/fill_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_fill_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fill_arbiter_if.sv
// SDRAM controller side of the line-fill arbiter: one transaction request
// handshake plus the read-beat and write-beat streams of the burst.
interface fill_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wnext;

    // Arbiter view: issues requests and write data, receives beats.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata,
        input  mem_rvalid,
        input  mem_wnext
    );

    // SDRAM controller view.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata,
        output mem_rvalid,
        output mem_wnext
    );
endinterface

// File: rtl/fill_arbiter.sv
// fill_arbiter: shares the single SDRAM controller port between the program
// cache fill requester (P) and the data cache fill/write-back requester (D).
// Each granted transaction is a fixed BURST_LEN-beat burst; ties between P
// and D are broken round-robin against the previous owner. Beat routing is
// combinational, while grant/done/request outputs are registered.
module fill_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              RST,
    // program cache side
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    output logic              p_gnt,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_rvalid,
    output logic              p_done,
    // data cache side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wnext,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    // SDRAM controller side
    fill_arbiter_if.master    mem,
    // status
    output logic              proto_err
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t            state_q,      state_d;
    owner_t            owner_q,      owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              mem_req_q,    mem_req_d;
    logic              p_gnt_q,      p_gnt_d;
    logic              d_gnt_q,      d_gnt_d;
    logic              p_done_q,     p_done_d;
    logic              d_done_q,     d_done_d;
    logic              proto_err_q,  proto_err_d;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    logic   in_xfer_s;
    logic   qual_beat_s;
    logic   bad_beat_s;
    logic   bad_ack_s;
    logic   grant_s;
    owner_t sel_owner_s;

    // Classify controller strobes against the current state and direction.
    always_comb begin
        in_xfer_s   = (state_q == ST_XFER);
        qual_beat_s = 1'b0;
        bad_beat_s  = 1'b0;
        if (in_xfer_s) begin
            if (we_q) begin
                qual_beat_s = mem.mem_wnext;
                bad_beat_s  = mem.mem_rvalid;
            end else begin
                qual_beat_s = mem.mem_rvalid;
                bad_beat_s  = mem.mem_wnext;
            end
        end else begin
            bad_beat_s = mem.mem_rvalid | mem.mem_wnext;
        end
        bad_ack_s = mem.mem_ack & (state_q != ST_GRANT);
    end

    // Pick the next owner from the live requests; a tie goes to the side
    // that did not own the port last.
    always_comb begin
        grant_s     = 1'b0;
        sel_owner_s = OWN_P;
        if (p_req && d_req) begin
            grant_s = 1'b1;
            if (last_owner_q == OWN_D) begin
                sel_owner_s = OWN_P;
            end else begin
                sel_owner_s = OWN_D;
            end
        end else if (p_req) begin
            grant_s     = 1'b1;
            sel_owner_s = OWN_P;
        end else if (d_req) begin
            grant_s     = 1'b1;
            sel_owner_s = OWN_D;
        end else begin
            grant_s     = 1'b0;
            sel_owner_s = OWN_P;
        end
    end

    // Next-state logic for the transaction sequencer and its registered outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_GRANT;
                    owner_d = sel_owner_s;
                    if (sel_owner_s == OWN_D) begin
                        addr_d = d_addr;
                        we_d   = d_we;
                    end else begin
                        addr_d = p_addr;
                        we_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (mem.mem_ack) begin
                    state_d = ST_XFER;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_XFER: begin
                if (qual_beat_s) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                // Requests are deliberately ignored here: a req still high
                // after done is only seen as a new transaction from IDLE.
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // Outputs are derived from the next state so they are flop outputs
        // that line up with the state they describe.
        mem_req_d   = (state_d == ST_GRANT);
        p_gnt_d     = (state_d != ST_IDLE) && (owner_d == OWN_P);
        d_gnt_d     = (state_d != ST_IDLE) && (owner_d == OWN_D);
        p_done_d    = (state_d == ST_DONE) && (owner_d == OWN_P);
        d_done_d    = (state_d == ST_DONE) && (owner_d == OWN_D);
        proto_err_d = proto_err_q | bad_beat_s | bad_ack_s;
    end

    // Sequencer registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_P;
            last_owner_q <= OWN_D;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            mem_req_q    <= 1'b0;
            p_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            p_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            p_gnt_q      <= p_gnt_d;
            d_gnt_q      <= d_gnt_d;
            p_done_q     <= p_done_d;
            d_done_q     <= d_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping and combinational beat routing
    // ------------------------------------------------------------------
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = d_wdata;

    assign p_gnt     = p_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign p_done    = p_done_q;
    assign d_done    = d_done_q;
    assign proto_err = proto_err_q;

    assign p_rdata  = mem.mem_rdata;
    assign d_rdata  = mem.mem_rdata;
    // A beat of the wrong type or outside XFER never reaches a cache.
    assign p_rvalid = mem.mem_rvalid & in_xfer_s & (owner_q == OWN_P);
    assign d_rvalid = mem.mem_rvalid & in_xfer_s & (owner_q == OWN_D) & ~we_q;
    assign d_wnext  = mem.mem_wnext  & in_xfer_s & (owner_q == OWN_D) &  we_q;

endmodule

// File: tb/tb_fill_arbiter.sv
// Directed bench for fill_arbiter: a BURST_LEN=4 instance carries the
// arbitration, write-back, protocol-error and reset cases; a BURST_LEN=8
// instance carries the long burst with a mid-burst stall. Expected beat
// data goes into a queue when driven and is popped when the DUT forwards it.
module tb_fill_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    // BURST_LEN = 4 instance
    logic          p_req, p_gnt, p_rvalid, p_done;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_rdata;
    logic          d_req, d_we, d_wnext, d_gnt, d_rvalid, d_done;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          proto_err;
    fill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m4();

    fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .RST(RST),
        .p_req(p_req), .p_addr(p_addr), .p_gnt(p_gnt), .p_rdata(p_rdata),
        .p_rvalid(p_rvalid), .p_done(p_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wnext(d_wnext), .d_gnt(d_gnt), .d_rdata(d_rdata),
        .d_rvalid(d_rvalid), .d_done(d_done),
        .mem(m4), .proto_err(proto_err)
    );

    // BURST_LEN = 8 instance
    logic          p8_req, p8_gnt, p8_rvalid, p8_done;
    logic [AW-1:0] p8_addr;
    logic [DW-1:0] p8_rdata;
    logic          d8_req, d8_we, d8_wnext, d8_gnt, d8_rvalid, d8_done;
    logic [AW-1:0] d8_addr;
    logic [DW-1:0] d8_wdata, d8_rdata;
    logic          proto_err8;
    fill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m8();

    fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(8)) u_dut8 (
        .clk(clk), .RST(RST),
        .p_req(p8_req), .p_addr(p8_addr), .p_gnt(p8_gnt), .p_rdata(p8_rdata),
        .p_rvalid(p8_rvalid), .p_done(p8_done),
        .d_req(d8_req), .d_we(d8_we), .d_addr(d8_addr), .d_wdata(d8_wdata),
        .d_wnext(d8_wnext), .d_gnt(d8_gnt), .d_rdata(d8_rdata),
        .d_rvalid(d8_rvalid), .d_done(d8_done),
        .mem(m8), .proto_err(proto_err8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge (+1) while the DUT4 sits in GRANT: acknowledge,
    // run four beats with one idle cycle after each, check the done pulse,
    // drop the request and check the port is released.
    task automatic run_txn(input logic is_d, input logic we, input logic [DW-1:0] base);
        logic [DW-1:0] val;
        check("mem_req_in_grant", m4.mem_req, 1'b1);
        m4.mem_ack = 1'b1;
        @(negedge clk);
        m4.mem_ack = 1'b0;
        #1;
        check("mem_req_after_ack", m4.mem_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            val = base + DW'(i);
            if (we) begin
                d_wdata      = val;
                m4.mem_wnext = 1'b1;
            end else begin
                m4.mem_rdata  = val;
                m4.mem_rvalid = 1'b1;
            end
            exp_q.push_back(val);
            #1;
            if (we) begin
                check("d_wnext_beat", d_wnext, 1'b1);
                check("p_rvalid_on_write", p_rvalid, 1'b0);
                if (d_wnext && exp_q.size() > 0) check("mem_wdata", m4.mem_wdata, exp_q.pop_front());
            end else if (is_d) begin
                check("d_rvalid_beat", d_rvalid, 1'b1);
                check("p_rvalid_leak", p_rvalid, 1'b0);
                if (d_rvalid && exp_q.size() > 0) check("d_rdata", d_rdata, exp_q.pop_front());
            end else begin
                check("p_rvalid_beat", p_rvalid, 1'b1);
                check("d_rvalid_leak", d_rvalid, 1'b0);
                if (p_rvalid && exp_q.size() > 0) check("p_rdata", p_rdata, exp_q.pop_front());
            end
            check("done_early", {p_done, d_done}, 2'b00);
            @(negedge clk);
            m4.mem_rvalid = 1'b0;
            m4.mem_wnext  = 1'b0;
            m4.mem_rdata  = 16'h0000;
            d_wdata       = val ^ 16'hFFFF;
            #1;
            check("mem_wdata_track", m4.mem_wdata, d_wdata);
            check("strobes_in_gap", {p_rvalid, d_rvalid, d_wnext}, 3'b000);
            check("gnt_held", {p_gnt, d_gnt}, is_d ? 2'b01 : 2'b10);
            if (i < 3) begin
                check("done_mid_burst", {p_done, d_done}, 2'b00);
            end else begin
                check("done_pulse", {p_done, d_done}, is_d ? 2'b01 : 2'b10);
            end
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);
        if (is_d) d_req = 1'b0;
        else      p_req = 1'b0;
        @(negedge clk);
        #1;
        check("done_one_cycle", {p_done, d_done}, 2'b00);
        check("gnt_released", {p_gnt, d_gnt}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        p_req = 1'b0; p_addr = 24'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 24'h0; d_wdata = 16'h0;
        m4.mem_ack = 1'b0; m4.mem_rdata = 16'h0; m4.mem_rvalid = 1'b0; m4.mem_wnext = 1'b0;
        p8_req = 1'b0; p8_addr = 24'h0; d8_req = 1'b0; d8_we = 1'b0;
        d8_addr = 24'h0; d8_wdata = 16'h1234;
        m8.mem_ack = 1'b0; m8.mem_rdata = 16'h0; m8.mem_rvalid = 1'b0; m8.mem_wnext = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", m4.mem_req, 1'b0);
        check("rst_gnt", {p_gnt, d_gnt}, 2'b00);
        check("rst_done", {p_done, d_done}, 2'b00);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_mem_we", m4.mem_we, 1'b0);
        check("rst_mem_req8", m8.mem_req, 1'b0);
        @(negedge clk);
        RST = 1'b0;

        // Single program fill
        p_addr = 24'h000120;
        p_req  = 1'b1;
        #1;
        check("mem_req_not_yet", m4.mem_req, 1'b0);
        @(negedge clk);
        #1;
        check("t1_mem_addr", m4.mem_addr, 24'h000120);
        check("t1_mem_we", m4.mem_we, 1'b0);
        check("t1_gnt", {p_gnt, d_gnt}, 2'b10);
        run_txn(1'b0, 1'b0, 16'h00A0);

        // Tie out of reset: P first, then D, then P again
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        p_addr = 24'h000100; d_addr = 24'h000200; d_we = 1'b0;
        p_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        #1;
        check("tie1_gnt", {p_gnt, d_gnt}, 2'b10);
        check("tie1_addr", m4.mem_addr, 24'h000100);
        run_txn(1'b0, 1'b0, 16'h1000);
        @(negedge clk);
        #1;
        check("tie2_gnt", {p_gnt, d_gnt}, 2'b01);
        check("tie2_addr", m4.mem_addr, 24'h000200);
        run_txn(1'b1, 1'b0, 16'h2000);
        p_addr = 24'h000140; d_addr = 24'h000240;
        p_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        #1;
        check("tie3_gnt", {p_gnt, d_gnt}, 2'b10);
        check("tie3_addr", m4.mem_addr, 24'h000140);
        run_txn(1'b0, 1'b0, 16'h3000);
        @(negedge clk);
        #1;
        check("tie4_gnt", {p_gnt, d_gnt}, 2'b01);
        run_txn(1'b1, 1'b0, 16'h4000);

        // Data write-back with gaps between beats
        d_addr = 24'h00FFF8; d_we = 1'b1; d_wdata = 16'h5555; d_req = 1'b1;
        @(negedge clk);
        #1;
        check("wb_gnt", {p_gnt, d_gnt}, 2'b01);
        check("wb_mem_we", m4.mem_we, 1'b1);
        check("wb_mem_addr", m4.mem_addr, 24'h00FFF8);
        run_txn(1'b1, 1'b1, 16'h5000);
        check("wb_proto_err", proto_err, 1'b0);
        d_we = 1'b0;

        // Read beat during GRANT is a protocol error and is not forwarded
        p_addr = 24'h000180; p_req = 1'b1;
        @(negedge clk);
        m4.mem_rvalid = 1'b1; m4.mem_rdata = 16'hEEEE;
        #1;
        check("early_beat_p_rvalid", {p_rvalid, d_rvalid}, 2'b00);
        check("early_beat_err_not_yet", proto_err, 1'b0);
        @(negedge clk);
        m4.mem_rvalid = 1'b0;
        #1;
        check("early_beat_proto_err", proto_err, 1'b1);
        run_txn(1'b0, 1'b0, 16'h6000);
        check("proto_err_sticky", proto_err, 1'b1);

        // Reset in the middle of a burst, data request pending
        p_addr = 24'h0001C0; p_req = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid_gnt", {p_gnt, d_gnt}, 2'b10);
        m4.mem_ack = 1'b1;
        @(negedge clk);
        m4.mem_ack = 1'b0;
        d_addr = 24'h0002C0; d_we = 1'b0; d_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m4.mem_rvalid = 1'b1;
            m4.mem_rdata  = 16'h0070 + 16'(i);
            #1;
            check("rstmid_p_rvalid", p_rvalid, 1'b1);
            @(negedge clk);
        end
        m4.mem_rvalid = 1'b0;
        #1;
        check("rstmid_before_gnt", {p_gnt, d_gnt}, 2'b10);
        RST = 1'b1;
        #1;
        check("rstmid_mem_req", m4.mem_req, 1'b0);
        check("rstmid_gnt_off", {p_gnt, d_gnt}, 2'b00);
        check("rstmid_no_done", {p_done, d_done}, 2'b00);
        check("rstmid_proto_clr", proto_err, 1'b0);
        p_req = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        #1;
        check("rstmid_idle", {p_gnt, d_gnt}, 2'b00);
        @(negedge clk);
        #1;
        check("rstmid_d_gnt", {p_gnt, d_gnt}, 2'b01);
        check("rstmid_d_addr", m4.mem_addr, 24'h0002C0);
        run_txn(1'b1, 1'b0, 16'h8000);

        // BURST_LEN = 8 fill with a 3-cycle stall before the 5th beat
        p8_addr = 24'h000400; p8_req = 1'b1;
        @(negedge clk);
        #1;
        check("b8_mem_req", m8.mem_req, 1'b1);
        check("b8_gnt", p8_gnt, 1'b1);
        check("b8_addr", m8.mem_addr, 24'h000400);
        m8.mem_ack = 1'b1;
        @(negedge clk);
        m8.mem_ack = 1'b0;
        #1;
        check("b8_mem_req_off", m8.mem_req, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check("b8_stall_gnt", p8_gnt, 1'b1);
                    check("b8_stall_done", p8_done, 1'b0);
                end
            end
            m8.mem_rvalid = 1'b1;
            m8.mem_rdata  = 16'h0090 + 16'(i);
            exp_q.push_back(16'h0090 + 16'(i));
            #1;
            check("b8_p_rvalid", p8_rvalid, 1'b1);
            check("b8_d_rvalid", d8_rvalid, 1'b0);
            check("b8_d_rdata", d8_rdata, m8.mem_rdata);
            if (p8_rvalid && exp_q.size() > 0) check("b8_p_rdata", p8_rdata, exp_q.pop_front());
            @(negedge clk);
            m8.mem_rvalid = 1'b0;
            #1;
            check("b8_gnt_held", p8_gnt, 1'b1);
            check("b8_done", p8_done, (i == 7) ? 1'b1 : 1'b0);
        end
        p8_req = 1'b0;
        @(negedge clk);
        #1;
        check("b8_release", {p8_gnt, p8_done}, 2'b00);
        check("b8_d_idle", {d8_gnt, d8_done, d8_wnext}, 3'b000);
        check("b8_mem_we", m8.mem_we, 1'b0);
        check("b8_mem_wdata", m8.mem_wdata, d8_wdata);
        check("b8_proto_err", proto_err8, 1'b0);
        check("b8_scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
